// File: rtl/multi_sensor_ahb_wrapper_if.sv
// rtl/multi_sensor_ahb_wrapper_if.sv - AHB slave bus bundle for multi_sensor_ahb_wrapper
// Also supplies default AHB field widths when the integrating project has not defined them.
`ifndef AHB_ADDR_BITS
`define AHB_ADDR_BITS 32
`endif
`ifndef AHB_DATA_BITS
`define AHB_DATA_BITS 32
`endif
`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_SIZE_BITS
`define AHB_SIZE_BITS 3
`endif
`ifndef AHB_BURST_BITS
`define AHB_BURST_BITS 3
`endif
`ifndef AHB_RESP_BITS
`define AHB_RESP_BITS 2
`endif

interface multi_sensor_ahb_wrapper_if;
  logic                         HSEL_SENSOR;
  logic [`AHB_ADDR_BITS-1:0]    HADDR;
  logic                         HWRITE;
  logic [`AHB_TRANS_BITS-1:0]   HTRANS;
  logic [`AHB_SIZE_BITS-1:0]    HSIZE;
  logic [`AHB_BURST_BITS-1:0]   HBURST;
  logic [`AHB_DATA_BITS-1:0]    HWDATA;
  logic                         HREADY;
  logic [`AHB_RESP_BITS-1:0]    HRESP;
  logic [`AHB_DATA_BITS-1:0]    HRDATA;

  modport master (
    output HSEL_SENSOR, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HSEL_SENSOR, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA,
    output HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/multi_sensor_ahb_wrapper.sv
// rtl/multi_sensor_ahb_wrapper.sv - AHB slave front-end for NUM_CH sensor channels
// Optional macro SENSOR_IRQ_EN adds sctrl_done/irq ports with per-channel pending/mask.
module multi_sensor_ahb_wrapper #(
  parameter int NUM_CH    = 4,
  parameter int ADDRWIDTH = 6,
  parameter int DATAWIDTH = 32
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  multi_sensor_ahb_wrapper_if.slave   ahb,
  output logic [NUM_CH-1:0]           sctrl_en,
  output logic [NUM_CH-1:0]           sctrl_clear,
  output logic [ADDRWIDTH-1:0]        sctrl_addr,
  input  logic [NUM_CH*DATAWIDTH-1:0] sctrl_out
`ifdef SENSOR_IRQ_EN
  ,
  input  logic [NUM_CH-1:0]           sctrl_done,
  output logic                        irq
`endif
);

  localparam int DB = `AHB_DATA_BITS;
  localparam logic [`AHB_RESP_BITS-1:0] RESP_OKAY  = '0;
  localparam logic [`AHB_RESP_BITS-1:0] RESP_ERROR = `AHB_RESP_BITS'(1);

  typedef enum logic [2:0] {S_IDLE, S_RD_WAIT, S_RD_DATA, S_ERR1, S_ERR2} state_t;
  typedef enum logic [2:0] {G_DATA, G_EN, G_CLR, G_STAT, G_MASK} reg_t;

  state_t                 r_state, w_next;
  logic [NUM_CH-1:0]      r_en, r_clear;
  logic [ADDRWIDTH-1:0]   r_addr;
  logic                   r_wr_pend;
  logic [3:0]             r_wr_ch, r_rd_ch;
  reg_t                   r_wr_reg, r_rd_reg;
  logic [DB-1:0]          r_rdata;

  logic [3:0]             w_ch;
  logic [11:0]            w_off;
  reg_t                   w_reg;
  logic                   w_err, w_accept, w_wdata_nz;
  logic [ADDRWIDTH-1:0]   w_idx;
  logic [NUM_CH-1:0]      w_wr_sel, w_pend, w_mask;
  logic [DATAWIDTH-1:0]   w_ch_data;
  logic                   w_en_bit, w_pend_bit, w_mask_bit;
  logic [DB-1:0]          w_rd_val;
  logic                   w_unused_ok;

  assign w_ch       = ahb.HADDR[15:12];
  assign w_off      = ahb.HADDR[11:0];
  assign w_idx      = ahb.HADDR[ADDRWIDTH+1:2];
  assign w_wdata_nz = |ahb.HWDATA;
  assign w_accept   = ahb.HSEL_SENSOR && ahb.HTRANS[1] &&
                      (r_state == S_IDLE || r_state == S_RD_DATA);
  assign w_unused_ok = ^{ahb.HBURST, ahb.HTRANS[0], ahb.HADDR[`AHB_ADDR_BITS-1:16]};

  assign sctrl_en    = r_en;
  assign sctrl_clear = r_clear;
  assign sctrl_addr  = r_addr;

  // Address-phase decode; any error condition suppresses all side effects.
  always_comb begin
    w_reg = G_DATA;
    w_err = 1'b0;
    if (w_off[11:8] == 4'h0 && w_off[1:0] == 2'b00) begin
      w_reg = G_DATA;
      w_err = ahb.HWRITE;
    end else if (w_off == 12'h100) begin
      w_reg = G_EN;
    end else if (w_off == 12'h200) begin
      w_reg = G_CLR;
      w_err = !ahb.HWRITE;
    end else if (w_off == 12'h300) begin
      w_reg = G_STAT;
`ifndef SENSOR_IRQ_EN
      w_err = ahb.HWRITE;
`endif
`ifdef SENSOR_IRQ_EN
    end else if (w_off == 12'h400) begin
      w_reg = G_MASK;
`endif
    end else begin
      w_err = 1'b1;
    end
    if (int'(w_ch) >= NUM_CH || ahb.HSIZE != 3'b010)
      w_err = 1'b1;
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      w_wr_sel[c] = r_wr_pend && (r_wr_ch == c[3:0]);
  end

  always_comb begin
    w_ch_data  = '0;
    w_en_bit   = 1'b0;
    w_pend_bit = 1'b0;
    w_mask_bit = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_rd_ch == c[3:0]) begin
        w_ch_data  = sctrl_out[c*DATAWIDTH +: DATAWIDTH];
        w_en_bit   = r_en[c];
        w_pend_bit = w_pend[c];
        w_mask_bit = w_mask[c];
      end
    end
    w_rd_val = '0;
    case (r_rd_reg)
      G_DATA:  w_rd_val[DATAWIDTH-1:0] = w_ch_data;
      G_EN:    w_rd_val[0] = w_en_bit;
      G_STAT:  w_rd_val[1:0] = {w_pend_bit, w_en_bit};
      G_MASK:  w_rd_val[0] = w_mask_bit;
      default: w_rd_val = '0;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RD_DATA: begin
        w_next = S_IDLE;
        if (w_accept) begin
          if (w_err)              w_next = S_ERR1;
          else if (!ahb.HWRITE)   w_next = S_RD_WAIT;
        end
      end
      S_RD_WAIT: w_next = S_RD_DATA;
      S_ERR1:    w_next = S_ERR2;
      S_ERR2:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ahb.HREADY = 1'b1;
    ahb.HRESP  = RESP_OKAY;
    ahb.HRDATA = '0;
    case (r_state)
      S_RD_WAIT: ahb.HREADY = 1'b0;
      S_RD_DATA: ahb.HRDATA = r_rdata;
      S_ERR1: begin
        ahb.HREADY = 1'b0;
        ahb.HRESP  = RESP_ERROR;
      end
      S_ERR2:    ahb.HRESP  = RESP_ERROR;
      default: ;
    endcase
  end

  // Writes commit at the end of their zero-wait data phase, when HWDATA is valid.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_en      <= '0;
      r_clear   <= '1;
      r_addr    <= '0;
      r_wr_pend <= 1'b0;
      r_wr_ch   <= '0;
      r_wr_reg  <= G_DATA;
      r_rd_ch   <= '0;
      r_rd_reg  <= G_DATA;
      r_rdata   <= '0;
    end else begin
      r_clear   <= '0;
      r_wr_pend <= w_accept && ahb.HWRITE && !w_err;
      if (w_accept) begin
        r_wr_ch  <= w_ch;
        r_wr_reg <= w_reg;
        if (!ahb.HWRITE && !w_err) begin
          r_rd_ch  <= w_ch;
          r_rd_reg <= w_reg;
          r_addr   <= w_idx;
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr_sel[c] && r_wr_reg == G_EN)  r_en[c]    <= w_wdata_nz;
        if (w_wr_sel[c] && r_wr_reg == G_CLR) r_clear[c] <= w_wdata_nz;
      end
      if (r_state == S_RD_WAIT)
        r_rdata <= w_rd_val;
    end
  end

`ifdef SENSOR_IRQ_EN
  logic [NUM_CH-1:0] r_pend, r_mask, r_done_q;
  logic              r_irq;

  assign w_pend = r_pend;
  assign w_mask = r_mask;
  assign irq    = r_irq;

  // Set is applied after the W1C so a coincident done edge is never lost.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_pend   <= '0;
      r_mask   <= '0;
      r_done_q <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_done_q <= sctrl_done;
      r_irq    <= |(r_pend & r_mask);
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr_sel[c] && r_wr_reg == G_MASK) r_mask[c] <= ahb.HWDATA[0];
        if (w_wr_sel[c] && r_wr_reg == G_STAT && ahb.HWDATA[1]) r_pend[c] <= 1'b0;
        if (sctrl_done[c] && !r_done_q[c]) r_pend[c] <= 1'b1;
      end
    end
  end
`else
  assign w_pend = '0;
  assign w_mask = '0;
`endif

endmodule
